// File: rtl/dma_pkg.sv
// dma_pkg: shared FSM states, descriptor field positions and completion flags for the DMA descriptor path
package dma_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, REPORT} state_t;
   localparam int WR_LEN_HI  = 47;
   localparam int WR_LEN_LO  = 32;
   localparam int RD_ADDR_HI = 63;
   localparam int RD_ADDR_LO = 32;
   localparam int RD_TAG_HI  = 19;
   localparam int RD_TAG_LO  = 16;
   localparam int RD_LEN_HI  = 15;
   localparam int RD_LEN_LO  = 0;
   localparam logic RX_FLAG = 1'b1;
   localparam logic TX_FLAG = 1'b0;
endpackage

// File: rtl/dma_desc_engine_if.sv
// dma_desc_engine_if: memory-move command bus between the descriptor engine and the packet mover
interface dma_desc_engine_if;
   logic        cmd_valid;
   logic        cmd_wr;
   logic [31:0] cmd_addr;
   logic [15:0] cmd_len;
   logic        cmd_ready;
   logic        cmd_done;
   modport master (output cmd_valid, cmd_wr, cmd_addr, cmd_len, input cmd_ready, cmd_done);
   modport slave  (input cmd_valid, cmd_wr, cmd_addr, cmd_len, output cmd_ready, cmd_done);
endinterface

// File: rtl/dma_desc_engine.sv
// dma_desc_engine: pops rx/tx descriptors, issues mover commands one at a time and pushes completions
module dma_desc_engine
   import dma_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_start_en,
   output logic        o_rden_pBufWR,
   input  logic [47:0] i_dout_pBufWR,
   input  logic        i_empty_pBufWR,
   output logic        o_rden_pBufRD,
   input  logic [63:0] i_dout_pBufRD,
   input  logic        i_empty_pBufRD,
   input  logic        i_rx_pkt_valid,
   input  logic [15:0] i_rx_pkt_len,
   output logic        o_rx_pkt_ack,
   dma_desc_engine_if.master cmd,
   output logic        o_wren_int,
   output logic [31:0] o_din_int,
   input  logic        i_full_int,
   output logic        o_wren_length,
   output logic [15:0] o_din_length,
   input  logic        i_full_length,
   output logic        o_wait_free_pBufWR,
   output logic        o_trunc
);
   state_t      state;
   logic        dir;
   logic        last_rx;
   logic [31:0] addr;
   logic [15:0] len;
   logic [15:0] wr_len;
   logic [15:0] rd_len;
   logic        rd_skip;
   logic        rx_trunc;
   logic        rx_c;
   logic        tx_c;
   logic        rx_go;
   logic        tx_go;
   logic        space;
   logic        unused_rd;
   assign wr_len   = i_dout_pBufWR[WR_LEN_HI:WR_LEN_LO];
   assign rd_len   = i_dout_pBufRD[RD_LEN_HI:RD_LEN_LO];
   assign rd_skip  = i_dout_pBufRD[RD_TAG_LO] | (rd_len == 16'd0);
   assign rx_trunc = i_rx_pkt_len > wr_len;
   assign unused_rd = ^{i_dout_pBufRD[31:20], i_dout_pBufRD[RD_TAG_HI:RD_TAG_LO+1]};
   // the ack guard stops a still-visible notification from being consumed twice
   assign rx_c  = i_start_en & i_rx_pkt_valid & ~i_empty_pBufWR & ~o_rx_pkt_ack;
   assign tx_c  = i_start_en & ~i_empty_pBufRD;
   assign rx_go = rx_c & (~tx_c | ~last_rx);
   assign tx_go = tx_c & ~rx_go;
   assign space = ~i_full_int & (~dir | ~i_full_length);
   assign cmd.cmd_wr   = dir;
   assign cmd.cmd_addr = addr;
   assign cmd.cmd_len  = len;
   assign o_din_int    = {dir ? RX_FLAG : TX_FLAG, addr[30:0]};
   assign o_din_length = len;
   assign o_wait_free_pBufWR = i_rx_pkt_valid & i_empty_pBufWR;
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         state         <= IDLE;
         dir           <= 1'b0;
         last_rx       <= 1'b0;
         addr          <= '0;
         len           <= '0;
         cmd.cmd_valid <= 1'b0;
         o_rden_pBufWR <= 1'b0;
         o_rden_pBufRD <= 1'b0;
         o_rx_pkt_ack  <= 1'b0;
         o_trunc       <= 1'b0;
         o_wren_int    <= 1'b0;
         o_wren_length <= 1'b0;
      end else begin
         o_rden_pBufWR <= 1'b0;
         o_rden_pBufRD <= 1'b0;
         o_rx_pkt_ack  <= 1'b0;
         o_trunc       <= 1'b0;
         o_wren_int    <= 1'b0;
         o_wren_length <= 1'b0;
         case (state)
            IDLE:
               if (rx_go) begin
                  o_rx_pkt_ack <= 1'b1;
                  if (i_rx_pkt_len != 16'd0) begin
                     dir           <= 1'b1;
                     addr          <= i_dout_pBufWR[31:0];
                     len           <= rx_trunc ? wr_len : i_rx_pkt_len;
                     o_trunc       <= rx_trunc;
                     o_rden_pBufWR <= 1'b1;
                     cmd.cmd_valid <= 1'b1;
                     state         <= ISSUE;
                  end
               end else if (tx_go) begin
                  dir           <= 1'b0;
                  addr          <= i_dout_pBufRD[RD_ADDR_HI:RD_ADDR_LO];
                  len           <= rd_len;
                  o_rden_pBufRD <= 1'b1;
                  cmd.cmd_valid <= ~rd_skip;
                  state         <= rd_skip ? REPORT : ISSUE;
               end
            ISSUE:
               if (cmd.cmd_ready) begin
                  cmd.cmd_valid <= 1'b0;
                  state         <= WAIT;
               end
            WAIT:
               if (cmd.cmd_done) begin
                  o_wren_int    <= space;
                  o_wren_length <= space & dir;
                  state         <= REPORT;
               end
            default:
               // a completion pushed last cycle ends the report; otherwise keep trying
               if (o_wren_int) begin
                  last_rx <= ~last_rx;
                  state   <= IDLE;
               end else begin
                  o_wren_int    <= space;
                  o_wren_length <= space & dir;
               end
         endcase
      end
endmodule

// File: tb/tb_dma_desc_engine.sv
// tb_dma_desc_engine: directed checks of grants, commands, completions, arbitration, backpressure and reset
module tb_dma_desc_engine;
   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_start_en = 1'b0;
   logic        o_rden_pBufWR;
   logic [47:0] i_dout_pBufWR = '0;
   logic        i_empty_pBufWR = 1'b1;
   logic        o_rden_pBufRD;
   logic [63:0] i_dout_pBufRD = '0;
   logic        i_empty_pBufRD = 1'b1;
   logic        i_rx_pkt_valid = 1'b0;
   logic [15:0] i_rx_pkt_len = '0;
   logic        o_rx_pkt_ack;
   logic        o_wren_int;
   logic [31:0] o_din_int;
   logic        i_full_int = 1'b0;
   logic        o_wren_length;
   logic [15:0] o_din_length;
   logic        i_full_length = 1'b0;
   logic        o_wait_free_pBufWR;
   logic        o_trunc;
   int checks = 0;
   int errors = 0;
   dma_desc_engine_if cmd_if ();
   dma_desc_engine dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start_en(i_start_en),
      .o_rden_pBufWR(o_rden_pBufWR), .i_dout_pBufWR(i_dout_pBufWR), .i_empty_pBufWR(i_empty_pBufWR),
      .o_rden_pBufRD(o_rden_pBufRD), .i_dout_pBufRD(i_dout_pBufRD), .i_empty_pBufRD(i_empty_pBufRD),
      .i_rx_pkt_valid(i_rx_pkt_valid), .i_rx_pkt_len(i_rx_pkt_len), .o_rx_pkt_ack(o_rx_pkt_ack),
      .cmd(cmd_if.master),
      .o_wren_int(o_wren_int), .o_din_int(o_din_int), .i_full_int(i_full_int),
      .o_wren_length(o_wren_length), .o_din_length(o_din_length), .i_full_length(i_full_length),
      .o_wait_free_pBufWR(o_wait_free_pBufWR), .o_trunc(o_trunc)
   );
   always #5 i_clk = ~i_clk;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(negedge i_clk);
   endtask
   task automatic grant_rx(input logic [15:0] plen, input logic [15:0] dlen, input logic [31:0] a);
      i_rx_pkt_valid = 1'b1;
      i_rx_pkt_len = plen;
      i_dout_pBufWR = {dlen, a};
      i_empty_pBufWR = 1'b0;
      tick;
      i_rx_pkt_valid = 1'b0;
      i_empty_pBufWR = 1'b1;
   endtask
   task automatic grant_tx(input logic [31:0] a, input logic [3:0] tag, input logic [15:0] l);
      i_dout_pBufRD = {a, 12'h0, tag, l};
      i_empty_pBufRD = 1'b0;
      tick;
      i_empty_pBufRD = 1'b1;
   endtask
   task automatic accept;
      cmd_if.cmd_ready = 1'b1;
      tick;
      cmd_if.cmd_ready = 1'b0;
   endtask
   task automatic finish_cmd;
      cmd_if.cmd_done = 1'b1;
      tick;
      cmd_if.cmd_done = 1'b0;
   endtask
   initial begin
      cmd_if.cmd_ready = 1'b0;
      cmd_if.cmd_done = 1'b0;
      #1;
      check("rst_cmd_valid", cmd_if.cmd_valid, 0);
      check("rst_wren_int", o_wren_int, 0);
      check("rst_din_int", o_din_int, 0);
      check("rst_rden", {o_rden_pBufWR, o_rden_pBufRD, o_rx_pkt_ack, o_trunc}, 0);
      tick;
      tick;
      i_rst_n = 1'b1;
      i_start_en = 1'b1;
      tick;
      // rx 60 bytes into a 2048 byte buffer
      grant_rx(16'd60, 16'd2048, 32'h0010_0000);
      check("rx_pop", {o_rden_pBufWR, o_rx_pkt_ack, o_trunc}, 3'b110);
      check("rx_cmd", {cmd_if.cmd_valid, cmd_if.cmd_wr, cmd_if.cmd_addr, cmd_if.cmd_len}, {2'b11, 32'h0010_0000, 16'd60});
      accept;
      check("rx_valid_drop", {cmd_if.cmd_valid, o_rden_pBufWR}, 0);
      tick;
      check("rx_wait_nopush", o_wren_int, 0);
      finish_cmd;
      check("rx_push", {o_wren_int, o_wren_length}, 2'b11);
      check("rx_int", o_din_int, 32'h8010_0000);
      check("rx_length", o_din_length, 16'd60);
      tick;
      check("rx_push_once", {o_wren_int, o_wren_length}, 0);
      // truncation
      grant_rx(16'd1600, 16'd1024, 32'h0030_0000);
      check("tr_trunc", o_trunc, 1);
      check("tr_cmd_len", cmd_if.cmd_len, 16'd1024);
      tick;
      check("tr_trunc_pulse", o_trunc, 0);
      accept;
      finish_cmd;
      check("tr_length", {o_wren_length, o_din_length}, {1'b1, 16'd1024});
      tick;
      // tx through the mover
      grant_tx(32'h0020_0040, 4'd0, 16'd128);
      check("tx_pop", {o_rden_pBufRD, o_rden_pBufWR}, 2'b10);
      check("tx_cmd", {cmd_if.cmd_valid, cmd_if.cmd_wr, cmd_if.cmd_len}, {2'b10, 16'd128});
      accept;
      finish_cmd;
      check("tx_push", {o_wren_int, o_wren_length}, 2'b10);
      check("tx_int", o_din_int, 32'h0020_0040);
      tick;
      // tag 1: buffer return only
      grant_tx(32'h0020_0040, 4'd1, 16'd16);
      check("skip_pop", {o_rden_pBufRD, cmd_if.cmd_valid}, 2'b10);
      tick;
      check("skip_push", {o_wren_int, o_wren_length, cmd_if.cmd_valid}, 3'b100);
      check("skip_int", o_din_int, 32'h0020_0040);
      tick;
      // zero-length rx: ack only
      grant_rx(16'd0, 16'd2048, 32'h0010_0000);
      check("zero_ack", {o_rx_pkt_ack, o_rden_pBufWR, cmd_if.cmd_valid}, 3'b100);
      tick;
      check("zero_idle", {o_rx_pkt_ack, cmd_if.cmd_valid, o_wren_int}, 0);
      // round robin with both sides pending throughout
      i_rx_pkt_valid = 1'b1;
      i_rx_pkt_len = 16'd64;
      i_dout_pBufWR = {16'd2048, 32'h0050_0000};
      i_empty_pBufWR = 1'b0;
      i_dout_pBufRD = {32'h0040_0000, 32'd32};
      i_empty_pBufRD = 1'b0;
      for (int r = 0; r < 4; r++) begin
         tick;
         check($sformatf("rr_grant%0d", r), {o_rden_pBufWR, o_rden_pBufRD}, (r % 2 == 0) ? 2'b10 : 2'b01);
         accept;
         finish_cmd;
         tick;
      end
      i_rx_pkt_valid = 1'b0;
      i_empty_pBufWR = 1'b1;
      i_empty_pBufRD = 1'b1;
      tick;
      // int FIFO full for 10 cycles after done
      grant_rx(16'd100, 16'd2048, 32'h0060_0000);
      accept;
      i_full_int = 1'b1;
      finish_cmd;
      for (int c = 0; c < 10; c++) begin
         check($sformatf("full_hold%0d", c), {o_wren_int, o_wren_length}, 0);
         tick;
      end
      i_full_int = 1'b0;
      tick;
      check("full_push", {o_wren_int, o_wren_length}, 2'b11);
      check("full_int", o_din_int, 32'h8060_0000);
      tick;
      // reset while waiting for done
      grant_rx(16'd200, 16'd2048, 32'h0070_0000);
      accept;
      tick;
      #2 i_rst_n = 1'b0;
      #1;
      check("mid_rst_out", {cmd_if.cmd_valid, o_wren_int, o_wren_length, o_rden_pBufWR, o_rx_pkt_ack, o_trunc}, 0);
      check("mid_rst_din", {o_din_int, o_din_length}, 0);
      tick;
      cmd_if.cmd_done = 1'b1;
      tick;
      cmd_if.cmd_done = 1'b0;
      i_rst_n = 1'b1;
      tick;
      tick;
      check("post_rst_nopush", {o_wren_int, o_wren_length, cmd_if.cmd_valid}, 0);
      i_start_en = 1'b0;
      i_rx_pkt_valid = 1'b1;
      #1;
      check("wait_free", o_wait_free_pBufWR, 1);
      i_empty_pBufWR = 1'b0;
      #1;
      check("wait_free_clr", o_wait_free_pBufWR, 0);
      tick;
      check("no_start_grant", {o_rden_pBufWR, o_rx_pkt_ack}, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/dma_desc_engine.md
# dma_desc_engine

Consumer side of the DMA descriptor path. Pops the receive-buffer (pBufWR) and transmit-buffer (pBufRD) descriptor FIFOs that the CPU peripheral fills, and issues memory-move commands to the packet mover. On each finished command it pushes a completion word into the int FIFO, and for receive also the length FIFO, so the CPU peripheral can read them back. It sits between the descriptor/completion FIFOs and the packet mover in the DMA part.

## Interface
- No parameters; widths are fixed by the descriptor formats.
- i_clk  in  1  clock
- i_rst_n  in  1  reset: asynchronous, active-low
- i_start_en  in  1  engine enable, from the CPU start register
- o_rden_pBufWR  out  1  pop, receive-descriptor FIFO
- i_dout_pBufWR  in  48  FWFT data: [47:32] buffer length in bytes, [31:0] byte address
- i_empty_pBufWR  in  1  receive-descriptor FIFO empty
- o_rden_pBufRD  out  1  pop, transmit-descriptor FIFO
- i_dout_pBufRD  in  64  FWFT data: [63:32] byte address, [19:16] tag, [15:0] length in bytes
- i_empty_pBufRD  in  1  transmit-descriptor FIFO empty
- i_rx_pkt_valid  in  1  an ingress packet is waiting
- i_rx_pkt_len  in  16  ingress packet length in bytes
- o_rx_pkt_ack  out  1  one-cycle pulse: packet notification consumed
- o_cmd_valid, o_cmd_wr, o_cmd_addr[31:0], o_cmd_len[15:0]  out  mover command; o_cmd_wr=1 means ingress→memory
- i_cmd_ready  in  1  mover accepts the command
- i_cmd_done  in  1  one-cycle pulse: the accepted command has finished
- o_wren_int  out  1  push, int FIFO
- o_din_int  out  32  {1'b1, addr[30:0]} for receive, {1'b0, addr[30:0]} for transmit
- i_full_int  in  1  int FIFO full
- o_wren_length  out  1  push, length FIFO
- o_din_length  out  16  bytes actually written
- i_full_length  in  1  length FIFO full
- o_wait_free_pBufWR  out  1  i_rx_pkt_valid is high and the receive-descriptor FIFO is empty
- o_trunc  out  1  one-cycle pulse: received packet truncated to the buffer length

## Operation
- FSM states: IDLE, ISSUE, WAIT, REPORT. A registered direction bit `dir` (1 = rx) selects the path.
- IDLE, rx candidate: i_start_en & i_rx_pkt_valid & !i_empty_pBufWR.
- IDLE, tx candidate: i_start_en & !i_empty_pBufRD.
- Both candidates: round-robin. Priority bit `last_rx` toggles at each REPORT exit. Reset value favours rx.
- rx grant:
  - latch addr = dout[31:0]; len = min(i_rx_pkt_len, dout[47:32]).
  - o_trunc pulses if i_rx_pkt_len > dout[47:32].
  - pulse o_rden_pBufWR and o_rx_pkt_ack; go to ISSUE.
- rx with i_rx_pkt_len == 0: pulse o_rx_pkt_ack only. No descriptor pop, no report; stay in IDLE.
- tx grant:
  - latch addr and len; pulse o_rden_pBufRD.
  - tag[0]==1 or len==0: skip the mover and go directly to REPORT (buffer return only).
  - otherwise go to ISSUE.
- ISSUE: hold o_cmd_valid with stable fields until i_cmd_ready, then go to WAIT.
- WAIT: on i_cmd_done go to REPORT. i_cmd_done is ignored in any other state.
- REPORT, rx: wait for !i_full_int & !i_full_length. Then pulse o_wren_int and o_wren_length together; o_din_length = latched len.
- REPORT, tx: wait for !i_full_int. Then pulse o_wren_int only.
- After REPORT go to IDLE.
- i_start_en falling mid-transfer: the current transfer completes through REPORT, and no new grant is made.
- o_wait_free_pBufWR is combinational from the inputs and independent of the FSM state.

## Timing
- Reset values: every output 0. FSM goes to IDLE, `last_rx`=0. Reset mid-transfer abandons the transfer and reports nothing.
- All outputs except o_wait_free_pBufWR are registered.
- Grant seen in IDLE at cycle N:
  - o_rden_*, o_rx_pkt_ack and o_trunc are high during N+1 only.
  - o_cmd_valid rises at N+1.
- i_cmd_ready high at cycle M: o_cmd_valid is low from M+1.
- i_cmd_done at cycle K with the needed FIFO space free: o_wren_* high during K+1 only. IDLE is re-entered at K+2.
- Skipped tx descriptor: o_wren_int is high in cycle N+2.
- At most one command is outstanding. A new command is never issued before the previous completion has been pushed.

## Structure
- Shared package `dma_pkg`:
  - state enum.
  - descriptor field positions (WR_LEN_HI=47, WR_LEN_LO=32; RD_ADDR 63:32, RD_TAG 19:16, RD_LEN 15:0).
  - completion flag bit 31 (RX_FLAG=1'b1, TX_FLAG=1'b0).
- Single flat module. The round-robin arbiter is two lines and does not get a sub-module.

## Test plan
- Rx, len 60, descriptor {len 2048, addr 0x0010_0000}:
  - command wr=1, addr 0x0010_0000, len 60.
  - after done: int 0x8010_0000, length 60.
- Rx, len 1600, descriptor len 1024: o_trunc pulses, o_cmd_len=1024, length FIFO receives 1024.
- Tx descriptor {addr 0x0020_0040, tag 0, len 128}:
  - command wr=0, len 128.
  - after done: int 0x0020_0040; o_wren_length stays 0.
- Tx descriptor tag=1:
  - no o_cmd_valid.
  - int 0x0020_0040 pushed two cycles after the grant.
- Rx and tx both pending continuously, 4 rounds: grants alternate rx, tx, rx, tx.
- i_full_int held high for 10 cycles after done:
  - no push during those cycles.
  - push happens the cycle after full drops.
- Reset asserted in WAIT: all outputs 0 and no completion is pushed. After release, i_rx_pkt_valid=1 with pBufWR empty → o_wait_free_pBufWR=1.
